// File: rtl/pkt_field_extractor.sv
// Packet field extractor: streams a 16-byte packet from byte-wide memory,
// decodes heartbeat / data / unknown types and presents the data-packet fields.
module pkt_field_extractor #(
   parameter int unsigned WORD_WIDTH = 16,
   parameter int unsigned MEM_WIDTH  = 8,
   parameter int unsigned ADDR_WIDTH = 11,
   parameter logic [WORD_WIDTH-1:0] PKT_HB   = 16'h0001,
   parameter logic [WORD_WIDTH-1:0] PKT_DATA = 16'h0002
) (
   input  logic                  clk,
   input  logic                  nrst,
   input  logic                  start,
   input  logic [ADDR_WIDTH-1:0] baseAddr,
   input  logic [WORD_WIDTH-1:0] myNodeID,
   output logic [ADDR_WIDTH-1:0] memAddr,
   output logic                  memRdEn,
   input  logic [MEM_WIDTH-1:0]  memData,
   output logic [WORD_WIDTH-1:0] fSourceID,
   output logic [WORD_WIDTH-1:0] fSourceHops,
   output logic [WORD_WIDTH-1:0] fQValue,
   output logic [WORD_WIDTH-1:0] fEnergyLeft,
   output logic [WORD_WIDTH-1:0] fHopsFromCH,
   output logic [WORD_WIDTH-1:0] fChosenCH,
   output logic                  iAmDestination,
   output logic                  en,
   output logic                  HB_Reset,
   output logic                  pktError,
   output logic                  busy,
   output logic                  done
);

   localparam int unsigned NBYTES = 16;
   localparam int unsigned NWORDS = 8;
   localparam int unsigned BUF_W  = NBYTES * MEM_WIDTH;
   localparam logic [ADDR_WIDTH-1:0] ADDR_ONE = {{(ADDR_WIDTH-1){1'b0}}, 1'b1};

   typedef enum logic [1:0] {IDLE, READ, DRAIN, DECODE} state_t;

   state_t                  state;
   logic [4:0]              cnt;
   logic [BUF_W-1:0]        shbuf;
   logic [WORD_WIDTH-1:0]   word [NWORDS];

   // Byte 0 ends up in the top of the shift buffer after all 16 shifts.
   always_comb begin
      for (int unsigned k = 0; k < NWORDS; k++) begin
         word[k] = shbuf[BUF_W-1-k*2*MEM_WIDTH -: WORD_WIDTH];
      end
   end

   always_ff @(posedge clk or negedge nrst) begin
      if (!nrst) begin
         state          <= IDLE;
         cnt            <= '0;
         shbuf          <= '0;
         memAddr        <= '0;
         memRdEn        <= 1'b0;
         fSourceID      <= '0;
         fSourceHops    <= '0;
         fQValue        <= '0;
         fEnergyLeft    <= '0;
         fHopsFromCH    <= '0;
         fChosenCH      <= '0;
         iAmDestination <= 1'b0;
         en             <= 1'b0;
         HB_Reset       <= 1'b0;
         pktError       <= 1'b0;
         busy           <= 1'b0;
         done           <= 1'b0;
      end else begin
         en       <= 1'b0;
         HB_Reset <= 1'b0;
         pktError <= 1'b0;
         done     <= 1'b0;
         case (state)
            IDLE: begin
               if (start) begin
                  memAddr <= baseAddr;
                  memRdEn <= 1'b1;
                  cnt     <= 5'd1;
                  busy    <= 1'b1;
                  state   <= READ;
               end
            end
            READ: begin
               // cnt tracks the edge index; data for byte i lands two edges after its address.
               if (cnt >= 5'd2) begin
                  shbuf <= {shbuf[BUF_W-MEM_WIDTH-1:0], memData};
               end
               if (cnt == 5'd16) begin
                  memRdEn <= 1'b0;
                  state   <= DRAIN;
               end else begin
                  memAddr <= memAddr + ADDR_ONE;
               end
               cnt <= cnt + 5'd1;
            end
            DRAIN: begin
               shbuf <= {shbuf[BUF_W-MEM_WIDTH-1:0], memData};
               state <= DECODE;
            end
            DECODE: begin
               if (word[0] == PKT_DATA) begin
                  fSourceID      <= word[1];
                  fSourceHops    <= word[2];
                  fQValue        <= word[3];
                  fEnergyLeft    <= word[4];
                  fHopsFromCH    <= word[5];
                  fChosenCH      <= word[6];
                  iAmDestination <= (word[7] == myNodeID);
                  en             <= 1'b1;
               end else if (word[0] == PKT_HB) begin
                  HB_Reset <= 1'b1;
               end else begin
                  pktError <= 1'b1;
               end
               done  <= 1'b1;
               busy  <= 1'b0;
               state <= IDLE;
            end
            default: state <= IDLE;
         endcase
      end
   end

endmodule
